gray_therm_dac_enc: RTL
=======================

Name: gray_therm_dac_enc

Overview:
Reverse path of the flash-ADC decode chain. Accepts a 5-bit Gray-coded sample, converts it to binary, then expands it to a 31-element thermometer word that drives a unit-element DAC. Data-weighted-averaging (DWA) rotation spreads element usage across samples. It is a 2-stage pipeline with valid/ready handshakes on both sides.

Parameters:
CODE_W, 5, width of the input code. The element count ELEM = 2**CODE_W - 1 is a derived localparam and is not overridable.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
in_valid  input  1  in_code is valid
in_ready  output  1  block accepts in_code this cycle
in_code  input  CODE_W  Gray-coded sample, using the same Gray sequence as the ADC decoder (00000, 00001, 00011, 00010, 00110, …)
out_valid  output  1  out_therm and out_bin are valid
out_ready  input  1  downstream accepts the output this cycle
out_therm  output  ELEM  rotated thermometer word; bit k drives DAC unit k
out_bin  output  CODE_W  binary value of the word on out_therm (count of ones)
dwa_ptr  output  CODE_W  current DWA start pointer, range 0..ELEM-1

Behaviour:
- Reset (async, active-high) forces:
  - out_valid = 0, out_therm = 0, out_bin = 0, dwa_ptr = 0
  - internal s1_valid = 0, s1_bin = 0
  - in_ready = 1 is combinational, so it reads 1 during reset.
- Pipeline enable: en = !out_valid | out_ready. in_ready = en (combinational). The whole pipeline stalls together.
- Input handshake: a transfer occurs when in_valid & in_ready.
- Stage 1, on en:
  - s1_valid <= in_valid.
  - s1_bin <= Gray-to-binary of in_code: b[MSB] = g[MSB]; b[i] = b[i+1] ^ g[i].
  - s1_bin is loaded only if in_valid; otherwise it holds.
- Stage 2, on en:
  - out_valid <= s1_valid.
  - If s1_valid:
    - out_bin <= s1_bin.
    - out_therm[(dwa_ptr + k) mod ELEM] = 1 for k = 0..s1_bin-1; all other bits 0.
    - dwa_ptr <= (dwa_ptr + s1_bin) mod ELEM. The sum is computed at CODE_W+1 bits, with a single conditional subtract of ELEM.
- Latency: 2 clk from input transfer to out_valid, with no stalls. Throughput is 1 word/cycle.
- Stall (out_valid & !out_ready):
  - out_therm, out_bin and dwa_ptr hold.
  - Stage 1 holds.
  - in_ready = 0.
- Boundary cases:
  - bin = 0: out_therm = 0, pointer unchanged, out_valid still asserted.
  - bin = ELEM (Gray 10000): all 31 bits = 1, pointer unchanged (adding ELEM mod ELEM = 0).
  - Wrap: ptr + bin > ELEM-1 wraps the ones through bit 0.
  - The pointer never equals ELEM.
- Bubbles: when s1_valid = 0 on en, out_valid drops to 0. out_therm and out_bin hold their last values and the pointer does not move.
- Reset mid-stream discards both stages. The first output after reset starts at dwa_ptr = 0.
- Outputs are registered. No combinational path from in_* to out_*. The only combinational path from out_ready to in_ready is in_ready = en.

Optional Feature:
Macro GRAY_THERM_DWA_EN.
- Defined: DWA rotation as above; dwa_ptr tracks the pointer.
- Undefined: plain thermometer, out_therm[k] = 1 for k < bin; dwa_ptr is held at 0 permanently; the pointer adder is not synthesized. Latency and handshake are unchanged.

Test Plan:
1. Reset, then in_code = 00010 (bin 3) with out_ready = 1 → 2 cycles later: out_valid = 1, out_bin = 3, out_therm = 0x00000007, dwa_ptr = 3.
2. Continuing from 1, in_code = 00110 (bin 4) → out_therm = 0x00000078, dwa_ptr = 7. Without GRAY_THERM_DWA_EN: out_therm = 0x0000000F, dwa_ptr = 0.
3. Wrap: drive samples until dwa_ptr = 29, then bin 4 (Gray 00110) → out_therm = 0x60000003, dwa_ptr = 2. Then Gray 10000 (bin 31) → out_therm = 0x7FFFFFFF, dwa_ptr = 2.
4. Backpressure: stream bin 1, 2, 3 back-to-back with out_ready = 0 for 3 cycles after the first output → in_ready = 0 during the stall, outputs and pointer are frozen, no data is lost. After release, the order is 1, 2, 3 and dwa_ptr = 6.
5. Bubble and zero: in_valid gap, then Gray 00000 → out_valid pulses, out_therm = 0, dwa_ptr unchanged.
6. Assert rst while two words are in flight → all outputs read 0 immediately (async) and in_ready = 1. The next input after rst deasserts produces a word starting at bit 0.

Source files
------------

// File: rtl/gray_therm_dac_enc.sv
// Gray code -> binary -> (optionally DWA-rotated) thermometer word for a unit-element DAC.
// Two registered stages, whole pipe stalls on out_valid & !out_ready; rotation enabled by GRAY_THERM_DWA_EN.
module gray_therm_dac_enc #(
  parameter int CODE_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CODE_W-1:0]     in_code,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2**CODE_W-2:0]  out_therm,
  output logic [CODE_W-1:0]     out_bin,
  output logic [CODE_W-1:0]     dwa_ptr
);

  localparam int ELEM = 2**CODE_W - 1;

  logic              en;
  logic              s1_valid;
  logic [CODE_W-1:0] s1_bin;
  logic [CODE_W-1:0] gray_bin;
  logic [ELEM-1:0]   base;
  logic [ELEM-1:0]   therm_next;

  assign en       = !out_valid | out_ready;
  assign in_ready = en;

  // Binary bit i is the parity of Gray bits i..MSB.
  always_comb begin
    gray_bin = '0;
    for (int i = 0; i < CODE_W; i++) begin
      gray_bin[i] = ^(in_code >> i);
    end
  end

  always_comb begin
    base = '0;
    for (int k = 0; k < ELEM; k++) begin
      base[k] = (s1_bin > CODE_W'(k));
    end
  end

`ifdef GRAY_THERM_DWA_EN
  logic [2*ELEM-1:0] rot_dbl;
  logic [CODE_W:0]   ptr_sum;

  // Rotate within ELEM bits: bits shifted past the top fold back to bit 0.
  always_comb begin
    rot_dbl    = {{ELEM{1'b0}}, base} << dwa_ptr;
    therm_next = rot_dbl[ELEM-1:0] | rot_dbl[2*ELEM-1:ELEM];
    ptr_sum    = {1'b0, dwa_ptr} + {1'b0, s1_bin};
    if (ptr_sum >= (CODE_W+1)'(ELEM)) begin
      ptr_sum = ptr_sum - (CODE_W+1)'(ELEM);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwa_ptr <= '0;
    end else if (en && s1_valid) begin
      dwa_ptr <= ptr_sum[CODE_W-1:0];
    end
  end
`else
  assign therm_next = base;
  assign dwa_ptr    = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_bin    <= '0;
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_therm <= '0;
    end else if (en) begin
      s1_valid  <= in_valid;
      if (in_valid) begin
        s1_bin <= gray_bin;
      end
      out_valid <= s1_valid;
      // Bubbles leave the last word on the outputs.
      if (s1_valid) begin
        out_bin   <= s1_bin;
        out_therm <= therm_next;
      end
    end
  end

endmodule
